aria_sbox_s2_seq: RTL and testbench

- Sequential forward ARIA S2 substitution engine for one 128-bit block. Applies S2 to each of the 16 bytes, or only to the bytes selected by a mask.
- The forward counterpart of the S2-inverse datapath. Each S2 lane is an aria_gfinv instance followed by the forward affine map, which is the exact inverse of the S2-inverse input affine.
- Used by the round-function path when area constraints call for fewer than 16 S-box instances.
- Valid/ready handshake on both sides; processes LANES bytes per cycle.

---
 rtl/aria_sbox_s2_seq.sv | 166 ++++++++++++++++
 tb/tb_aria_sbox_s2_seq.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aria_sbox_s2_seq.sv
// Sequential forward ARIA S2 substitution of one 128-bit block, LANES bytes per beat.
// Each lane is a GF(2^8) inverse followed by the forward S2 affine map.

module aria_gfinv (
    input  logic [7:0] i_x,
    output logic [7:0] o_y
);
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] t;
        p = '0;
        t = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ t;
            t = {t[6:0], 1'b0} ^ (t[7] ? 8'h1B : 8'h00);
        end
        return p;
    endfunction

    logic [7:0] w_sq;
    logic [7:0] w_acc;

    // x^254 = x^-1 (and 0 -> 0), formed as x^2 * x^4 * ... * x^128
    always_comb begin
        w_sq  = i_x;
        w_acc = 8'h01;
        for (int i = 1; i < 8; i++) begin
            w_sq  = gf_mul(w_sq, w_sq);
            w_acc = gf_mul(w_acc, w_sq);
        end
        o_y = w_acc;
    end
endmodule

module aria_s2_lane (
    input  logic [7:0] i_x,
    output logic [7:0] o_y
);
    // Column i is the image of inverse-bit i; constant 0xE2 gives S2(0)=0xE2
    localparam logic [7:0][7:0] A_COL = {8'h5F, 8'hFB, 8'hA7, 8'h26,
                                         8'h83, 8'hC6, 8'hFD, 8'hAC};

    logic [7:0] w_inv;

    aria_gfinv u_inv (
        .i_x (i_x),
        .o_y (w_inv)
    );

    always_comb begin
        o_y = 8'hE2;
        for (int i = 0; i < 8; i++) begin
            if (w_inv[i]) o_y = o_y ^ A_COL[i];
        end
    end
endmodule

module aria_sbox_s2_seq #(
    parameter int LANES = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] din,
    input  logic [15:0]  byte_en,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] dout
);
    localparam int NBEAT = 16 / LANES;
    localparam int CW    = (NBEAT > 1) ? $clog2(NBEAT) : 1;

    if (LANES != 1 && LANES != 2 && LANES != 4 && LANES != 8 && LANES != 16) begin : g_bad_lanes
        $error("aria_sbox_s2_seq: LANES must be 1, 2, 4, 8 or 16");
    end

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [127:0]            r_blk;
    logic [127:0]            r_dout;
    logic [127:0]            w_blk_nxt;
    logic [15:0]             r_en;
    logic [CW-1:0]           r_cnt;
    logic                    w_last;
    logic [LANES-1:0][3:0]   w_rev;
    logic [LANES-1:0][7:0]   w_lane_in;
    logic [LANES-1:0][7:0]   w_lane_out;

    assign w_last = (r_cnt == CW'(NBEAT - 1));

    // Byte i sits at bit offset 8*(15-i); byte_en uses the same MSB-first order (bit 15 = byte 0)
    always_comb begin
        w_rev     = '0;
        w_lane_in = '0;
        for (int l = 0; l < LANES; l++) begin
            w_rev[l]     = 4'(15 - (int'(r_cnt) * LANES + l));
            w_lane_in[l] = r_blk[{w_rev[l], 3'b000} +: 8];
        end
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        aria_s2_lane u_lane (
            .i_x (w_lane_in[l]),
            .o_y (w_lane_out[l])
        );
    end

    always_comb begin
        w_blk_nxt = r_blk;
        for (int l = 0; l < LANES; l++) begin
            if (r_en[w_rev[l]]) w_blk_nxt[{w_rev[l], 3'b000} +: 8] = w_lane_out[l];
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) w_state_nxt = S_BUSY;
            end
            S_BUSY: begin
                if (w_last) w_state_nxt = S_DONE;
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_blk   <= '0;
            r_en    <= '0;
            r_cnt   <= '0;
            r_dout  <= '0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_blk <= din;
                        r_en  <= byte_en;
                        r_cnt <= '0;
                    end
                end
                S_BUSY: begin
                    r_blk <= w_blk_nxt;
                    r_cnt <= w_last ? '0 : r_cnt + 1'b1;
                    if (w_last) r_dout <= w_blk_nxt;
                end
                default: ;
            endcase
        end
    end

    assign dout = r_dout;
endmodule

// File: tb/tb_aria_sbox_s2_seq.sv
// Bench for aria_sbox_s2_seq: one instance per legal LANES, checked against an S2 table
// built from brute-force GF inversion and a row-parity affine map.

module tb_aria_sbox_s2_seq;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst;
    logic [4:0]        iv, ir, ov, orr;
    logic [4:0][127:0] dn, dq;
    logic [4:0][15:0]  be;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] s2_tab  [256];
    logic [7:0] inv_tab [256];

    for (genvar g = 0; g < 5; g++) begin : g_dut
        aria_sbox_s2_seq #(.LANES(1 << g)) u_dut (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (iv[g]),
            .in_ready  (ir[g]),
            .din       (dn[g]),
            .byte_en   (be[g]),
            .out_valid (ov[g]),
            .out_ready (orr[g]),
            .dout      (dq[g])
        );
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1);
    end

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [8:0] acc;
        logic [8:0] aa;
        acc = '0;
        aa  = {1'b0, a};
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ aa;
            aa = aa << 1;
            if (aa[8]) aa = aa ^ 9'h11B;
        end
        return acc[7:0];
    endfunction

    task automatic build_tables();
        logic [7:0] rows [8];
        logic [7:0] inv, o;
        rows = '{8'hEA, 8'hFC, 8'hB7, 8'hC3, 8'hC2, 8'h73, 8'hC6, 8'h6F};
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            for (int j = 0; j < 8; j++) o[j] = ^(inv & rows[j]);
            s2_tab[x] = o ^ 8'hE2;
        end
        for (int x = 0; x < 256; x++) inv_tab[s2_tab[x]] = 8'(x);
    endtask

    function automatic logic [127:0] blk_model(input logic [127:0] d, input logic [15:0] e);
        logic [127:0] r;
        logic [7:0]   b;
        for (int i = 0; i < 16; i++) begin
            b = d[127-8*i -: 8];
            if (e[15-i]) b = s2_tab[b];
            r[127-8*i -: 8] = b;
        end
        return r;
    endfunction

    function automatic logic [127:0] rand_blk();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic run_block(input int g, input logic [127:0] d, input logic [15:0] e,
                             output logic [127:0] res, output int lat);
        @(negedge clk);
        dn[g] = d; be[g] = e; iv[g] = 1'b1;
        @(posedge clk); #1;
        iv[g] = 1'b0;
        lat = 0;
        while (!ov[g] && lat < 64) begin
            @(posedge clk); #1;
            lat++;
        end
        res = dq[g];
        @(negedge clk); orr[g] = 1'b1;
        @(posedge clk); #1; orr[g] = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        for (int g = 0; g < 5; g++) begin
            n_tests++;
            if ({ir[g], ov[g], dq[g]} !== {1'b1, 1'b0, 128'h0}) begin
                n_fail++;
                $display("FAIL reset_state lanes=%0d: got rdy=%b vld=%b dout=%h want 1 0 0",
                         1 << g, ir[g], ov[g], dq[g]);
            end
        end
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic test_l16_zero();
        logic [127:0] res;
        int lat;
        run_block(4, 128'h0, 16'hFFFF, res, lat);
        n_tests++;
        if (res !== {16{8'hE2}}) begin
            n_fail++; $display("FAIL l16_zero_dout: got %h want %h", res, {16{8'hE2}});
        end
        n_tests++;
        if (lat !== 1) begin
            n_fail++; $display("FAIL l16_latency: got %0d want 1", lat);
        end
    endtask

    task automatic test_l4_vector();
        logic [127:0] res, want;
        int lat;
        want = 128'hE24E54FC94C24ACC620D6A463C4D8BD1;
        run_block(2, 128'h000102030405060708090A0B0C0D0E0F, 16'hFFFF, res, lat);
        n_tests++;
        if (res !== want) begin
            n_fail++; $display("FAIL l4_vector_dout: got %h want %h", res, want);
        end
        n_tests++;
        if (lat !== 4) begin
            n_fail++; $display("FAIL l4_latency: got %0d want 4", lat);
        end
    endtask

    task automatic test_mask();
        logic [127:0] res, d, want;
        int lat;
        d = 128'h000102030405060708090A0B0C0D0E0F;
        want = blk_model(d, 16'hAAAA);
        run_block(2, d, 16'hAAAA, res, lat);
        n_tests++;
        if (res !== want) begin
            n_fail++; $display("FAIL mask_aaaa: got %h want %h", res, want);
        end
        n_tests++;
        if (res[127:112] !== 16'hE201) begin
            n_fail++; $display("FAIL mask_byte01: got %h want e201", res[127:112]);
        end
    endtask

    task automatic test_roundtrip();
        int perm [256];
        bit seen [256];
        int tmp, j, lat, ncoll;
        logic [127:0] d, res, back;
        for (int g = 0; g < 5; g++) begin
            for (int i = 0; i < 256; i++) begin perm[i] = i; seen[i] = 1'b0; end
            for (int i = 255; i > 0; i--) begin
                j = $urandom_range(i, 0);
                tmp = perm[i]; perm[i] = perm[j]; perm[j] = tmp;
            end
            ncoll = 0;
            for (int b = 0; b < 16; b++) begin
                for (int i = 0; i < 16; i++) d[127-8*i -: 8] = 8'(perm[16*b+i]);
                run_block(g, d, 16'hFFFF, res, lat);
                for (int i = 0; i < 16; i++) begin
                    back[127-8*i -: 8] = inv_tab[res[127-8*i -: 8]];
                    if (seen[res[127-8*i -: 8]]) ncoll++;
                    seen[res[127-8*i -: 8]] = 1'b1;
                end
                n_tests++;
                if (back !== d) begin
                    n_fail++; $display("FAIL roundtrip lanes=%0d: got %h want %h", 1 << g, back, d);
                end
                n_tests++;
                if (lat !== (16 >> g)) begin
                    n_fail++; $display("FAIL rt_latency lanes=%0d: got %0d want %0d", 1 << g, lat, 16 >> g);
                end
            end
            n_tests++;
            if (ncoll !== 0) begin
                n_fail++; $display("FAIL collisions lanes=%0d: got %0d want 0", 1 << g, ncoll);
            end
        end
    endtask

    task automatic test_random();
        logic [127:0] d, res, want;
        logic [15:0] e;
        int g, lat;
        for (int k = 0; k < 40; k++) begin
            g = $urandom_range(4, 0);
            d = rand_blk();
            case (k % 4)
                0: e = 16'h0000;
                1: e = 16'hFFFF;
                default: e = 16'($urandom);
            endcase
            want = blk_model(d, e);
            run_block(g, d, e, res, lat);
            n_tests++;
            if (res !== want || lat !== (16 >> g)) begin
                n_fail++;
                $display("FAIL random lanes=%0d en=%h: got %h lat=%0d want %h lat=%0d",
                         1 << g, e, res, lat, want, 16 >> g);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [127:0] d, want;
        logic [15:0] e;
        int cyc, bad;
        d = rand_blk(); e = 16'($urandom); want = blk_model(d, e);
        @(negedge clk); dn[2] = d; be[2] = e; iv[2] = 1'b1;
        @(posedge clk); #1; iv[2] = 1'b0;
        cyc = 0;
        while (!ov[2] && cyc < 64) begin @(posedge clk); #1; cyc++; end
        bad = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk); iv[2] = 1'b1; dn[2] = rand_blk();
            @(posedge clk); #1;
            if (ov[2] !== 1'b1 || ir[2] !== 1'b0 || dq[2] !== want) bad++;
        end
        n_tests++;
        if (bad !== 0) begin
            n_fail++; $display("FAIL backpressure_hold: got %0d bad cycles want 0 (dout=%h want %h)",
                               bad, dq[2], want);
        end
        @(negedge clk); iv[2] = 1'b0; orr[2] = 1'b1;
        @(posedge clk); #1; orr[2] = 1'b0;
        n_tests++;
        if ({ov[2], ir[2]} !== 2'b01) begin
            n_fail++; $display("FAIL backpressure_release: got vld=%b rdy=%b want 0 1", ov[2], ir[2]);
        end
        n_tests++;
        if (dq[2] !== want) begin
            n_fail++; $display("FAIL dout_kept_idle: got %h want %h", dq[2], want);
        end
    endtask

    task automatic test_busy_ignore();
        logic [127:0] d, want;
        int cyc, rdy_hi;
        d = rand_blk(); want = blk_model(d, 16'hFFFF);
        @(negedge clk); dn[0] = d; be[0] = 16'hFFFF; iv[0] = 1'b1;
        @(posedge clk); #1;
        cyc = 0; rdy_hi = 0;
        while (!ov[0] && cyc < 64) begin
            dn[0] = rand_blk(); be[0] = 16'($urandom);
            if (ir[0]) rdy_hi++;
            @(posedge clk); #1; cyc++;
        end
        iv[0] = 1'b0;
        n_tests++;
        if (dq[0] !== want || cyc !== 16 || rdy_hi !== 0) begin
            n_fail++; $display("FAIL busy_ignore: got %h lat=%0d rdy_hi=%0d want %h lat=16 rdy_hi=0",
                               dq[0], cyc, rdy_hi, want);
        end
        @(negedge clk); orr[0] = 1'b1;
        @(posedge clk); #1; orr[0] = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [127:0] d, res, want;
        int lat, vld_seen;
        @(negedge clk); dn[2] = rand_blk(); be[2] = 16'hFFFF; iv[2] = 1'b1;
        @(posedge clk); #1; iv[2] = 1'b0;
        @(posedge clk);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        n_tests++;
        if ({ir[2], ov[2], dq[2]} !== {1'b1, 1'b0, 128'h0}) begin
            n_fail++; $display("FAIL reset_mid_state: got rdy=%b vld=%b dout=%h want 1 0 0",
                               ir[2], ov[2], dq[2]);
        end
        @(negedge clk); rst = 1'b0;
        vld_seen = 0;
        repeat (6) begin @(posedge clk); #1; if (ov[2]) vld_seen++; end
        n_tests++;
        if (vld_seen !== 0) begin
            n_fail++; $display("FAIL reset_mid_no_valid: got %0d valid cycles want 0", vld_seen);
        end
        d = rand_blk(); want = blk_model(d, 16'h5A3C);
        run_block(2, d, 16'h5A3C, res, lat);
        n_tests++;
        if (res !== want || lat !== 4) begin
            n_fail++; $display("FAIL reset_mid_next: got %h lat=%0d want %h lat=4", res, lat, want);
        end
    endtask

    initial begin
        rst = 1'b1; iv = '0; orr = '0; dn = '0; be = '0;
        build_tables();
        test_reset();
        test_l16_zero();
        test_l4_vector();
        test_mask();
        test_roundtrip();
        test_random();
        test_backpressure();
        test_busy_ignore();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
